// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehaze frame controller.
// Mode codes, reset defaults, FSM encoding and small helpers.
package dehaze_pkg;

  localparam logic [1:0] DH_MODE_DEHAZE = 2'd0;
  localparam logic [1:0] DH_MODE_TRANS  = 2'd1;
  localparam logic [1:0] DH_MODE_DARK   = 2'd2;
  localparam logic [1:0] DH_MODE_BYPASS = 2'd3;

  localparam logic [7:0] DH_THRE_RST = 8'd20;
  localparam logic [7:0] DH_ATMO_MIN = 8'd100;
  localparam logic [7:0] DH_ATMO_RST = 8'hFF;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } dh_state_e;

  function automatic logic [10:0] sat_inc11(
    input logic [10:0] v
  );
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [7:0] atmo_blend(
    input logic [7:0] a,
    input logic [7:0] m
  );
    logic [9:0] s;
    s = 10'(a) * 10'd3 + 10'(m) + 10'd2;
    return s[9:2];
  endfunction

endpackage

// File: rtl/vip_frame_geom_chk.sv
// Frame geometry checker: vsync/href edges, pixel and
// line counters, sticky line error and frame error flag.
module vip_frame_geom_chk
  import dehaze_pkg::*;
#(
  parameter logic [10:0] HDISP = 11'd800,
  parameter logic [10:0] VDISP = 11'd600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  input  logic clken,
  input  logic start,
  input  logic active,
  output logic rise,
  output logic fall,
  output logic err
);

  logic        vsync_d_q;
  logic        href_d_q;
  logic [10:0] pix_q;
  logic [10:0] pix_d;
  logic [10:0] line_q;
  logic [10:0] line_d;
  logic        lerr_q;
  logic        lerr_d;
  logic        href_fall;
  logic        pix_hit;

  assign rise      = vsync & ~vsync_d_q;
  assign fall      = ~vsync & vsync_d_q;
  assign href_fall = ~href & href_d_q;
  assign pix_hit   = clken & href;

  // Counter next-state; a frame start restarts geometry and
  // counts a pixel arriving on the very same cycle.
  always_comb begin
    pix_d  = pix_q;
    line_d = line_q;
    lerr_d = lerr_q;
    if (start) begin
      pix_d  = {10'd0, pix_hit};
      line_d = '0;
      lerr_d = 1'b0;
    end else if (active) begin
      if (href_fall) begin
        lerr_d = lerr_q | (pix_q != HDISP);
        line_d = sat_inc11(line_q);
        pix_d  = '0;
      end else if (pix_hit) begin
        pix_d = sat_inc11(pix_q);
      end
    end
    err = lerr_d | (line_d != VDISP);
  end

  // Edge-detect history and geometry counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_q <= 1'b0;
      href_d_q  <= 1'b0;
      pix_q     <= '0;
      line_q    <= '0;
      lerr_q    <= 1'b0;
    end else begin
      vsync_d_q <= vsync;
      href_d_q  <= href;
      pix_q     <= pix_d;
      line_q    <= line_d;
      lerr_q    <= lerr_d;
    end
  end

endmodule

// File: rtl/dehaze_frame_ctrl.sv
// Dehaze frame controller: frame FSM, boundary-applied
// host config and clamped/smoothed atmospheric light.
module dehaze_frame_ctrl
  import dehaze_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP = 11'd800,
  parameter logic [10:0] IMG_VDISP = 11'd600,
  parameter logic [7:0]  ATMO_MIN  = DH_ATMO_MIN,
  parameter logic [7:0]  THRE_RST  = DH_THRE_RST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_thre,
  input  logic [7:0]  meas_atmo,
  output logic [1:0]  act_mode,
  output logic [7:0]  act_thre,
  output logic [7:0]  act_atmo,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  dh_state_e   state_q;
  dh_state_e   state_d;
  logic        start_q;
  logic        start_d;
  logic        done_q;
  logic        done_d;
  logic        ferr_q;
  logic        ferr_d;
  logic        pend_q;
  logic        pend_d;
  logic [1:0]  pmode_q;
  logic [1:0]  pmode_d;
  logic [7:0]  pthre_q;
  logic [7:0]  pthre_d;
  logic [1:0]  mode_q;
  logic [1:0]  mode_d;
  logic [7:0]  thre_q;
  logic [7:0]  thre_d;
  logic [7:0]  atmo_q;
  logic [7:0]  atmo_d;
  logic        seen_q;
  logic        seen_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  logic        rise;
  logic        fall;
  logic        geom_err;
  logic        go;
  logic        endf;
  logic        active;
  logic        accept;
  logic [7:0]  m;

  assign active = (state_q == ST_ACTIVE);
  assign go     = (state_q == ST_IDLE) & rise;
  assign endf   = active & fall;

  vip_frame_geom_chk #(
    .HDISP (IMG_HDISP),
    .VDISP (IMG_VDISP)
  ) u_geom (
    .clk    (clk),
    .rst_n  (rst_n),
    .vsync  (per_frame_vsync),
    .href   (per_frame_href),
    .clken  (per_frame_clken),
    .start  (go),
    .active (active),
    .rise   (rise),
    .fall   (fall),
    .err    (geom_err)
  );

  // Next state for FSM, pulses, config and atmo filter.
  always_comb begin
    state_d = state_q;
    start_d = go;
    done_d  = endf;
    ferr_d  = endf & geom_err;
    pend_d  = pend_q;
    pmode_d = pmode_q;
    pthre_d = pthre_q;
    mode_d  = mode_q;
    thre_d  = thre_q;
    atmo_d  = atmo_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    accept  = cfg_valid & ~pend_q;
    m = (meas_atmo < ATMO_MIN) ? ATMO_MIN : meas_atmo;

    unique case (state_q)
      ST_SYNC:   if (!per_frame_vsync) state_d = ST_IDLE;
      ST_IDLE:   if (rise) state_d = ST_ACTIVE;
      ST_ACTIVE: if (fall) state_d = ST_IDLE;
      default:   state_d = ST_SYNC;
    endcase

    if (go && pend_q) begin
      mode_d = pmode_q;
      thre_d = pthre_q;
      pend_d = 1'b0;
    end
    if (accept) begin
      pend_d  = 1'b1;
      pmode_d = cfg_mode;
      pthre_d = cfg_thre;
    end

    if (endf && !geom_err) begin
      cnt_d  = cnt_q + 16'd1;
      atmo_d = seen_q ? atmo_blend(atmo_q, m) : m;
      seen_d = 1'b1;
    end
  end

  // All controller state, registered outputs included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pend_q  <= 1'b0;
      pmode_q <= DH_MODE_DEHAZE;
      pthre_q <= THRE_RST;
      mode_q  <= DH_MODE_DEHAZE;
      thre_q  <= THRE_RST;
      atmo_q  <= DH_ATMO_RST;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      pend_q  <= pend_d;
      pmode_q <= pmode_d;
      pthre_q <= pthre_d;
      mode_q  <= mode_d;
      thre_q  <= thre_d;
      atmo_q  <= atmo_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_ready   = ~pend_q;
  assign act_mode    = mode_q;
  assign act_thre    = thre_q;
  assign act_atmo    = atmo_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign frame_err   = ferr_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// Bench for dehaze_frame_ctrl on a shrunk 8x4 geometry.
// Frame results are queued at vsync fall, checked at done.
module tb_dehaze_frame_ctrl;

  localparam int HD = 8;
  localparam int VD = 4;

  logic        clk;
  logic        rst_n;
  logic        vsync;
  logic        href;
  logic        clken;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_thre;
  logic [7:0]  meas_atmo;
  logic [1:0]  act_mode;
  logic [7:0]  act_thre;
  logic [7:0]  act_atmo;
  logic        frame_start;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;

  dehaze_frame_ctrl #(
    .IMG_HDISP (11'd8),
    .IMG_VDISP (11'd4),
    .ATMO_MIN  (8'd100),
    .THRE_RST  (8'd20)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .per_frame_vsync (vsync),
    .per_frame_href  (href),
    .per_frame_clken (clken),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_mode        (cfg_mode),
    .cfg_thre        (cfg_thre),
    .meas_atmo       (meas_atmo),
    .act_mode        (act_mode),
    .act_thre        (act_thre),
    .act_atmo        (act_atmo),
    .frame_start     (frame_start),
    .frame_done      (frame_done),
    .frame_err       (frame_err),
    .frame_cnt       (frame_cnt)
  );

  typedef struct {
    int err;
    int cnt;
    int atmo;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   starts = 0;
  int   cyc = 0;
  int   m_cnt;
  int   m_atmo;
  bit   m_first;
  int   s0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every done pulse pops one result.
  always @(posedge clk) begin
    #1;
    if (frame_start) starts++;
    if (frame_done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cyc", cyc, mon_e.cyc);
        chk("frame_err", int'(frame_err), mon_e.err);
        chk("frame_cnt", int'(frame_cnt), mon_e.cnt);
        chk("act_atmo", int'(act_atmo), mon_e.atmo);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_cnt   = 0;
    m_atmo  = 255;
    m_first = 1'b1;
  endtask

  task automatic drive_line(int npix, bit first_on);
    int got;
    got  = 0;
    href = 1'b1;
    while (got < npix) begin
      clken = (first_on && got == 0) ? 1'b1
            : ($urandom_range(3) != 0);
      if (clken) got++;
      tick();
    end
    href  = 1'b0;
    clken = 1'b0;
    tick();
    clken = 1'b1;
    tick();
    clken = 1'b0;
    tick();
  endtask

  task automatic drive_frame(int nl, int short_ln, int meas,
                             bit href_at_rise);
    exp_t e;
    int   mm;
    bit   err;
    vsync = 1'b1;
    if (!href_at_rise) begin
      tick();
      tick();
    end
    for (int l = 0; l < nl; l++)
      drive_line((l == short_ln) ? HD - 1 : HD,
                 href_at_rise && l == 0);
    meas_atmo = 8'(meas);
    vsync = 1'b0;
    err = (short_ln >= 0) || (nl != VD);
    if (!err) begin
      mm = (meas < 100) ? 100 : meas;
      m_cnt = (m_cnt + 1) & 16'hFFFF;
      m_atmo = m_first ? mm : (3 * m_atmo + mm + 2) >> 2;
      m_first = 1'b0;
    end
    e.err  = int'(err);
    e.cnt  = m_cnt;
    e.atmo = m_atmo;
    e.cyc  = cyc + 1;
    sb.push_back(e);
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    clken = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode = 2'd0;
    cfg_thre = 8'd0;
    meas_atmo = 8'd0;
    model_reset();
    tick();
    tick();
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_mode", int'(act_mode), 0);
    chk("rst_thre", int'(act_thre), 20);
    chk("rst_atmo", int'(act_atmo), 255);
    chk("rst_cnt", int'(frame_cnt), 0);
    chk("rst_start", int'(frame_start), 0);
    chk("rst_done", int'(frame_done), 0);
    rst_n = 1'b1;
    tick();
    tick();

    drive_frame(VD, -1, 200, 1'b0);
    drive_frame(VD, -1, 200, 1'b0);
    drive_frame(VD, -1, 200, 1'b1);
    chk("cnt3", int'(frame_cnt), 3);
    drive_frame(VD, 1, 90, 1'b0);
    drive_frame(0, -1, 90, 1'b0);
    drive_frame(VD + 1, -1, 90, 1'b0);

    fork
      drive_frame(VD, -1, 200, 1'b0);
      begin
        repeat (10) tick();
        cfg_valid = 1'b1;
        cfg_mode = 2'd3;
        cfg_thre = 8'd30;
        tick();
        cfg_valid = 1'b0;
        chk("ready_fall", int'(cfg_ready), 0);
        tick();
        chk("mode_hold", int'(act_mode), 0);
      end
    join
    chk("thre_hold", int'(act_thre), 20);
    chk("ready_pend", int'(cfg_ready), 0);
    vsync = 1'b1;
    tick();
    chk("fs_pulse", int'(frame_start), 1);
    chk("mode_apply", int'(act_mode), 3);
    chk("thre_apply", int'(act_thre), 30);
    chk("ready_back", int'(cfg_ready), 1);
    tick();
    chk("fs_one", int'(frame_start), 0);
    drive_frame(VD, -1, 200, 1'b0);

    vsync = 1'b1;
    cfg_valid = 1'b1;
    cfg_mode = 2'd1;
    cfg_thre = 8'd50;
    tick();
    cfg_valid = 1'b0;
    chk("same_fs", int'(frame_start), 1);
    chk("same_mode", int'(act_mode), 3);
    chk("same_thre", int'(act_thre), 30);
    chk("same_ready", int'(cfg_ready), 0);
    drive_frame(VD, -1, 200, 1'b0);
    vsync = 1'b1;
    tick();
    chk("next_mode", int'(act_mode), 1);
    chk("next_thre", int'(act_thre), 50);
    chk("next_ready", int'(cfg_ready), 1);
    drive_frame(VD, -1, 200, 1'b0);

    vsync = 1'b1;
    tick();
    tick();
    href = 1'b1;
    clken = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("arst_cnt", int'(frame_cnt), 0);
    chk("arst_atmo", int'(act_atmo), 255);
    chk("arst_mode", int'(act_mode), 0);
    chk("arst_thre", int'(act_thre), 20);
    chk("arst_start", int'(frame_start), 0);
    model_reset();
    tick();
    tick();
    s0 = starts;
    rst_n = 1'b1;
    tick();
    href = 1'b0;
    clken = 1'b0;
    tick();
    for (int l = 0; l < VD; l++) drive_line(HD, 1'b0);
    vsync = 1'b0;
    repeat (4) tick();
    chk("skip_start", starts, s0);
    chk("skip_cnt", int'(frame_cnt), 0);

    drive_frame(VD, -1, 40, 1'b0);
    chk("clamp_atmo", int'(act_atmo), 100);
    drive_frame(VD, -1, 200, 1'b0);
    chk("blend_atmo", int'(act_atmo), 125);
    chk("post_starts", starts, s0 + 2);

    repeat (5) tick();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
